// File: rtl/list_accum_pkg.sv
// list_accum_pkg: shared encodings for the linked-list walker.
//   mode_t  - reduction selected on start (SUM, MAX, CNT, XOR)
//   state_t - walker control states
package list_accum_pkg;

  typedef enum logic [1:0] {
    MODE_SUM = 2'd0,
    MODE_MAX = 2'd1,
    MODE_CNT = 2'd2,
    MODE_XOR = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD_VAL,
    ST_LOAD_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/list_accum_if.sv
// list_accum_if: read-only port between the walker and an external list RAM.
//   mem_rd    - read strobe (master -> slave)
//   mem_addr  - read address (master -> slave)
//   mem_rdata - read data, valid the cycle after mem_rd (slave -> master)
interface list_accum_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/list_accum_dp.sv
// list_accum_dp: walker datapath - node pointer, accumulator, node counter,
// sticky SUM carry flag and the reduction op mux.
//   clk, rst  - clock, synchronous active-low reset
//   load      - start accepted: latch mode, ptr<=head_addr, clear acc/nodes/ovf
//   mode      - reduction mode, captured on load
//   head_addr - first node address
//   acc_en    - fold rdata into the accumulator and count the node
//   ptr_en    - advance ptr to next_ptr
//   rdata     - node value from memory
//   next_ptr  - next-node address from memory
//   ptr, acc, nodes, ovf - registered state
module list_accum_dp
  import list_accum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] head_addr,
  input  logic              acc_en,
  input  logic              ptr_en,
  input  logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] next_ptr,
  output logic [ADDR_W-1:0] ptr,
  output logic [DATA_W-1:0] acc,
  output logic [CNT_W-1:0]  nodes,
  output logic              ovf
);

  mode_t             mode_q;
  logic [DATA_W:0]   sum_ext;
  logic [CNT_W-1:0]  nodes_inc;
  logic [DATA_W-1:0] acc_nxt;

  assign sum_ext   = {1'b0, acc} + {1'b0, rdata};
  assign nodes_inc = nodes + CNT_W'(1);

  always_comb begin
    acc_nxt = acc;
    case (mode_q)
      MODE_SUM: acc_nxt = sum_ext[DATA_W-1:0];
      MODE_MAX: acc_nxt = (rdata > acc) ? rdata : acc;
      MODE_CNT: acc_nxt = DATA_W'(nodes_inc);
      MODE_XOR: acc_nxt = acc ^ rdata;
      default:  acc_nxt = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= MODE_SUM;
      ptr    <= '0;
      acc    <= '0;
      nodes  <= '0;
      ovf    <= 1'b0;
    end else if (load) begin
      mode_q <= mode_t'(mode);
      ptr    <= head_addr;
      acc    <= '0;
      nodes  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (acc_en) begin
        acc   <= acc_nxt;
        nodes <= nodes_inc;
        if (mode_q == MODE_SUM && sum_ext[DATA_W]) ovf <= 1'b1;
      end
      if (ptr_en) ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/list_accum.sv
// list_accum: walks a null-terminated linked list in external RAM and
// reduces node values (sum, unsigned max, count, xor).
//   clk, rst   - clock, synchronous active-low reset
//   start      - begin walk (honoured only in IDLE/DONE)
//   mode       - 0 SUM, 1 MAX, 2 CNT, 3 XOR
//   head_addr  - first node address, 0 = empty list
//   mem        - list RAM read port (master)
//   busy       - walk in progress
//   DONE       - result valid, held until next accepted start
//   err        - loop guard tripped
//   ovf        - SUM carry-out seen during this walk
//   result_out - reduction result
//   nodes      - nodes visited
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_IDLE      | after reset, waiting for start
// ST_FETCH     | read value word of head node
// ST_LOAD_VAL  | rdata = value; fold it in, read next-pointer word
// ST_LOAD_NEXT | rdata = next; stop, trip guard, or read next value
// ST_DONE      | results frozen, waiting for start
module list_accum
  import list_accum_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int MAX_NODES = 256,
  parameter int CNT_W     = $clog2(MAX_NODES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] head_addr,
  list_accum_if.master      mem,
  output logic              busy,
  output logic              DONE,
  output logic              err,
  output logic              ovf,
  output logic [DATA_W-1:0] result_out,
  output logic [CNT_W-1:0]  nodes
);

  state_t            state;
  logic              accept;
  logic              at_limit;
  logic              cont;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] next_ptr;

  assign accept   = start && (state == ST_IDLE || state == ST_DONE);
  assign next_ptr = mem.mem_rdata[ADDR_W-1:0];
  assign at_limit = (nodes == CNT_W'(MAX_NODES));
  // A null next ends the walk cleanly even when the guard count is reached.
  assign cont     = (next_ptr != '0) && !at_limit;

  list_accum_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .mode      (mode),
    .head_addr (head_addr),
    .acc_en    (state == ST_LOAD_VAL),
    .ptr_en    (state == ST_LOAD_NEXT && cont),
    .rdata     (mem.mem_rdata),
    .next_ptr  (next_ptr),
    .ptr       (ptr),
    .acc       (result_out),
    .nodes     (nodes),
    .ovf       (ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      DONE  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            err <= 1'b0;
            if (head_addr == '0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              DONE  <= 1'b1;
            end else begin
              state <= ST_FETCH;
              busy  <= 1'b1;
              DONE  <= 1'b0;
            end
          end
        end
        ST_FETCH:    state <= ST_LOAD_VAL;
        ST_LOAD_VAL: state <= ST_LOAD_NEXT;
        ST_LOAD_NEXT: begin
          if (cont) begin
            state <= ST_LOAD_VAL;
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
            DONE  <= 1'b1;
            err   <= (next_ptr != '0);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          DONE  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  // The next-node read issues straight from rdata so each node costs two cycles.
  always_comb begin
    mem.mem_rd   = 1'b0;
    mem.mem_addr = '0;
    case (state)
      ST_FETCH: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = ptr;
      end
      ST_LOAD_VAL: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = ptr + ADDR_W'(1);
      end
      ST_LOAD_NEXT: begin
        if (cont) begin
          mem.mem_rd   = 1'b1;
          mem.mem_addr = next_ptr;
        end
      end
      default: begin
        mem.mem_rd   = 1'b0;
        mem.mem_addr = '0;
      end
    endcase
  end

endmodule
